// File: rtl/mario_jump_ctrl_pkg.sv
// ============================================================================
// Module      : mario_jump_ctrl_pkg
// Description : Shared state codes and default physics constants for Mario's
//               vertical motion controller and sprite renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mario_jump_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } mario_state_e;

    localparam int unsigned c_y_w      = 10;
    localparam int unsigned c_y_init   = 411;  // sprite bottom sits on floor row 440
    localparam int unsigned c_y_min    = 0;
    localparam int unsigned c_jump_v   = 12;
    localparam int unsigned c_max_fall = 8;
    localparam int unsigned c_vw       = 4;

endpackage

`default_nettype wire

// File: rtl/mario_y_stepper.sv
// ============================================================================
// Module      : mario_y_stepper
// Description : Loadable pixel-step counter with an up/down Y register; moves
//               Y by one pixel per clk while steps remain (dir=1 moves down).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mario_y_stepper
    import mario_jump_ctrl_pkg::*;
#(
    parameter int unsigned VW     = c_vw,
    parameter int unsigned Y_INIT = c_y_init
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [VW-1:0]    count,
    input  logic             dir,
    input  logic             stop,
    output logic [c_y_w-1:0] y,
    output logic             done
);

    localparam logic [VW-1:0]    c_cnt_one = VW'(1);
    localparam logic [c_y_w-1:0] c_y_one   = c_y_w'(1);

    logic [VW-1:0]    r_count;
    logic [c_y_w-1:0] r_y;

    // stop discards the remaining steps without moving, so the sprite halts
    // on the exact pixel where the stop condition was seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= c_y_w'(Y_INIT);
            r_count <= '0;
        end else if (load) begin
            r_count <= count;
        end else if (r_count != '0) begin
            if (stop) begin
                r_count <= '0;
            end else begin
                r_y     <= dir ? (r_y + c_y_one) : (r_y - c_y_one);
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    assign y    = r_y;
    assign done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mario_jump_ctrl.sv
// ============================================================================
// Module      : mario_jump_ctrl
// Description : Vertical motion FSM for Mario: jump impulse and gravity per
//               frame tick, applied as single-pixel steps per clk.
//               Optional MARIO_JUMP_HOLD_EN: releasing jump ends the rise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mario_jump_ctrl
    import mario_jump_ctrl_pkg::*;
#(
    parameter int unsigned Y_INIT   = c_y_init,
    parameter int unsigned Y_MIN    = c_y_min,
    parameter int unsigned JUMP_V   = c_jump_v,
    parameter int unsigned MAX_FALL = c_max_fall,
    parameter int unsigned VW       = c_vw
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             jump,
    input  logic             ground,
    output logic [c_y_w-1:0] mario_y,
    output logic [1:0]       state,
    output logic             busy
);

    localparam logic [VW-1:0]    c_jump_vel = VW'(JUMP_V);
    localparam logic [VW-1:0]    c_max_vel  = VW'(MAX_FALL);
    localparam logic [VW-1:0]    c_vel_one  = VW'(1);
    localparam logic [c_y_w-1:0] c_top_y    = c_y_w'(Y_MIN);

    mario_state_e     r_state;
    logic [VW-1:0]    r_vel;

    logic             w_done;
    logic [c_y_w-1:0] w_y;
    logic             w_tick_go;
    logic             w_at_top;
    logic             w_rise_end;
    logic [VW-1:0]    w_vel_dec;
    logic [VW-1:0]    w_vel_inc;
    logic             w_load;
    logic [VW-1:0]    w_count;
    logic             w_stop;
    logic             w_dir;

    // A tick arriving mid-step is dropped entirely.
    assign w_tick_go = tick & w_done;
    assign w_at_top  = (w_y == c_top_y);
    assign w_vel_dec = r_vel - c_vel_one;
    assign w_vel_inc = (r_vel >= c_max_vel) ? c_max_vel : (r_vel + c_vel_one);

`ifdef MARIO_JUMP_HOLD_EN
    assign w_rise_end = (w_vel_dec == '0) | ~jump;
`else
    assign w_rise_end = (w_vel_dec == '0);
`endif

    always_comb begin
        w_load  = 1'b0;
        w_count = '0;
        if (w_tick_go) begin
            case (r_state)
                ST_GROUND: begin
                    if (!ground) begin
                        w_load  = 1'b1;
                        w_count = c_vel_one;
                    end else if (jump) begin
                        w_load  = 1'b1;
                        w_count = c_jump_vel;
                    end
                end
                ST_RISE: begin
                    w_load  = 1'b1;
                    w_count = w_rise_end ? c_vel_one : w_vel_dec;
                end
                ST_FALL: begin
                    w_load  = 1'b1;
                    w_count = w_vel_inc;
                end
                default: begin
                    w_load  = 1'b0;
                    w_count = '0;
                end
            endcase
        end
    end

    // Rising ignores ground so bars are passable from below.
    assign w_stop = (r_state == ST_RISE) ? w_at_top :
                    (r_state == ST_FALL) ? ground   : 1'b0;
    assign w_dir  = (r_state == ST_FALL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_GROUND;
            r_vel   <= '0;
        end else if (w_tick_go) begin
            case (r_state)
                ST_GROUND: begin
                    if (!ground) begin
                        r_state <= ST_FALL;
                        r_vel   <= c_vel_one;
                    end else if (jump) begin
                        r_state <= ST_RISE;
                        r_vel   <= c_jump_vel;
                    end
                end
                ST_RISE: begin
                    if (w_rise_end) begin
                        r_state <= ST_FALL;
                        r_vel   <= c_vel_one;
                    end else begin
                        r_vel   <= w_vel_dec;
                    end
                end
                ST_FALL: begin
                    r_vel <= w_vel_inc;
                end
                default: begin
                    r_state <= ST_GROUND;
                    r_vel   <= '0;
                end
            endcase
        end else if (!w_done && w_stop) begin
            if (r_state == ST_RISE) begin
                r_state <= ST_FALL;
                r_vel   <= c_vel_one;
            end else begin
                r_state <= ST_GROUND;
                r_vel   <= '0;
            end
        end
    end

    mario_y_stepper #(
        .VW     (VW),
        .Y_INIT (Y_INIT)
    ) u_stepper (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .count (w_count),
        .dir   (w_dir),
        .stop  (w_stop),
        .y     (w_y),
        .done  (w_done)
    );

    assign mario_y = w_y;
    assign state   = r_state;
    assign busy    = ~w_done;

endmodule

`default_nettype wire
